// File: rtl/ex_operand_bypass_if.sv
// Forwarding-control types and the EX operand-bypass bus interface.
// Latency: n/a (type and port-group declarations only).
// Backpressure: ex_ready_i from the consumer; op_valid_o/op_a_o/op_b_o hold while it is low.
// Ports (interface members): fw_cntrl_i, ex_valid_i, flush_i, ex_ready_i, rs1/rs2_data_i,
//   mem_result_i, mem_is_load_i, mem_load_valid_i, mem_load_data_i, wb_result_i  -> bypass
//   op_a_o, op_b_o, op_valid_o, stall_o, stall_cnt_o                             <- bypass

package core;
    typedef enum logic [1:0] {
        NONE_STAGE = 2'd0,
        MEM_STAGE  = 2'd1,
        WB_STAGE   = 2'd2
    } fw_stage_e;

    typedef enum logic [1:0] {
        RS_NONE = 2'd0,
        RS1     = 2'd1,
        RS2     = 2'd2,
        RS1_RS2 = 2'd3
    } fw_regs_e;

    typedef struct packed {
        fw_stage_e stage;
        fw_regs_e  regs;
    } fw_cntrl_bus_t;
endpackage

interface ex_operand_bypass_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    core::fw_cntrl_bus_t fw_cntrl_i;
    logic                ex_valid_i;
    logic                flush_i;
    logic                ex_ready_i;
    logic [XLEN-1:0]     rs1_data_i;
    logic [XLEN-1:0]     rs2_data_i;
    logic [XLEN-1:0]     mem_result_i;
    logic                mem_is_load_i;
    logic                mem_load_valid_i;
    logic [XLEN-1:0]     mem_load_data_i;
    logic [XLEN-1:0]     wb_result_i;
    logic [XLEN-1:0]     op_a_o;
    logic [XLEN-1:0]     op_b_o;
    logic                op_valid_o;
    logic                stall_o;
    logic [CNT_W-1:0]    stall_cnt_o;

    // Pipeline side: drives control/data, observes operands.
    modport master (
        output fw_cntrl_i, ex_valid_i, flush_i, ex_ready_i,
        output rs1_data_i, rs2_data_i, mem_result_i, mem_is_load_i,
        output mem_load_valid_i, mem_load_data_i, wb_result_i,
        input  op_a_o, op_b_o, op_valid_o, stall_o, stall_cnt_o
    );

    // Bypass unit side.
    modport slave (
        input  fw_cntrl_i, ex_valid_i, flush_i, ex_ready_i,
        input  rs1_data_i, rs2_data_i, mem_result_i, mem_is_load_i,
        input  mem_load_valid_i, mem_load_data_i, wb_result_i,
        output op_a_o, op_b_o, op_valid_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/ex_operand_bypass.sv
// EX-stage operand bypass: selects rs/MEM/WB operands, interlocks on load-use, holds under backpressure.
// Latency: 0 cycles in PASS (combinational mux); load-use adds one cycle per missing load-data cycle.
// Backpressure: ex_ready_i low with valid operands captures them into hold regs and keeps them stable.
// Ports: clk, rst (sync, active-low), bus (ex_operand_bypass_if.slave).

module ex_operand_bypass #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_operand_bypass_if.slave   bus
);
    typedef enum logic [1:0] {
        PASS = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           r_state;
    logic [XLEN-1:0]  r_hold_a;
    logic [XLEN-1:0]  r_hold_b;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_stage_fwd;
    logic             w_fwd_a;
    logic             w_fwd_b;
    logic [XLEN-1:0]  w_fwd_src;
    logic [XLEN-1:0]  w_mux_a;
    logic [XLEN-1:0]  w_mux_b;
    logic             w_luh;
    logic [XLEN-1:0]  w_op_a;
    logic [XLEN-1:0]  w_op_b;
    logic             w_op_valid;
    logic             w_stall;

    // Only explicit MEM/WB requests forward; any other stage value falls back to the register file.
    assign w_stage_fwd = (bus.fw_cntrl_i.stage == core::MEM_STAGE) ||
                         (bus.fw_cntrl_i.stage == core::WB_STAGE);
    assign w_fwd_a = w_stage_fwd && ((bus.fw_cntrl_i.regs == core::RS1) ||
                                     (bus.fw_cntrl_i.regs == core::RS1_RS2));
    assign w_fwd_b = w_stage_fwd && ((bus.fw_cntrl_i.regs == core::RS2) ||
                                     (bus.fw_cntrl_i.regs == core::RS1_RS2));

    // A load in MEM supplies its returned data rather than its address-calc ALU result.
    assign w_fwd_src = (bus.fw_cntrl_i.stage == core::MEM_STAGE) ?
                       (bus.mem_is_load_i ? bus.mem_load_data_i : bus.mem_result_i) :
                       bus.wb_result_i;

    assign w_mux_a = w_fwd_a ? w_fwd_src : bus.rs1_data_i;
    assign w_mux_b = w_fwd_b ? w_fwd_src : bus.rs2_data_i;

    assign w_luh = bus.ex_valid_i &&
                   (bus.fw_cntrl_i.stage == core::MEM_STAGE) &&
                   (bus.fw_cntrl_i.regs != core::RS_NONE) &&
                   bus.mem_is_load_i && !bus.mem_load_valid_i;

    always_comb begin
        w_op_a     = w_mux_a;
        w_op_b     = w_mux_b;
        w_op_valid = 1'b0;
        w_stall    = 1'b0;
        if (!rst) begin
            w_op_a = '0;
            w_op_b = '0;
        end else begin
            unique case (r_state)
                PASS: begin
                    w_op_valid = bus.ex_valid_i && !w_luh;
                    w_stall    = w_luh;
                end
                WAIT: begin
                    w_op_valid = bus.mem_load_valid_i;
                    w_stall    = !bus.mem_load_valid_i;
                end
                HOLD: begin
                    w_op_a     = r_hold_a;
                    w_op_b     = r_hold_b;
                    w_op_valid = 1'b1;
                end
                default: begin
                    w_op_valid = 1'b0;
                    w_stall    = 1'b0;
                end
            endcase
            // A killed instruction neither transfers nor freezes the front end.
            if (bus.flush_i) begin
                w_op_valid = 1'b0;
                w_stall    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= PASS;
            r_hold_a    <= '0;
            r_hold_b    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (bus.flush_i) begin
                r_state <= PASS;
            end else begin
                unique case (r_state)
                    PASS: begin
                        if (w_luh) begin
                            r_state <= WAIT;
                        end else if (w_op_valid && !bus.ex_ready_i) begin
                            r_hold_a <= w_mux_a;
                            r_hold_b <= w_mux_b;
                            r_state  <= HOLD;
                        end
                    end
                    WAIT: begin
                        if (bus.mem_load_valid_i) begin
                            if (bus.ex_ready_i) begin
                                r_state <= PASS;
                            end else begin
                                r_hold_a <= w_mux_a;
                                r_hold_b <= w_mux_b;
                                r_state  <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (bus.ex_ready_i) begin
                            r_state <= PASS;
                        end
                    end
                    default: r_state <= PASS;
                endcase
            end
        end
    end

    assign bus.op_a_o      = w_op_a;
    assign bus.op_b_o      = w_op_b;
    assign bus.op_valid_o  = w_op_valid;
    assign bus.stall_o     = w_stall;
    assign bus.stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_ex_operand_bypass.sv
// Self-checking bench for ex_operand_bypass: directed scenarios plus randomized traffic vs a rule model.
// Latency: checks outputs 1ns after the falling edge, inputs change only on falling edges.
// Backpressure: ex_ready_i randomized; held operands are compared against the model's captured copy.

module tb_ex_operand_bypass;
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    ex_operand_bypass_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    ex_operand_bypass #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: "an instruction's operands are parked" / "waiting on load data".
    bit          m_parked;
    bit          m_waiting;
    logic [31:0] m_pa;
    logic [31:0] m_pb;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic idle();
        bus.fw_cntrl_i.stage  = core::NONE_STAGE;
        bus.fw_cntrl_i.regs   = core::RS_NONE;
        bus.ex_valid_i        = 1'b1;
        bus.flush_i           = 1'b0;
        bus.ex_ready_i        = 1'b1;
        bus.rs1_data_i        = 32'h0;
        bus.rs2_data_i        = 32'h0;
        bus.mem_result_i      = 32'h0;
        bus.mem_is_load_i     = 1'b0;
        bus.mem_load_valid_i  = 1'b0;
        bus.mem_load_data_i   = 32'h0;
        bus.wb_result_i       = 32'h0;
    endtask

    // Compare current outputs with the model, then advance the model over the coming rising edge.
    task automatic eval();
        logic [31:0] ea, eb, src;
        bit fwd, fa, fb, luh, ev, es;
        #1;
        fwd = (bus.fw_cntrl_i.stage == core::MEM_STAGE) || (bus.fw_cntrl_i.stage == core::WB_STAGE);
        fa  = fwd && (bus.fw_cntrl_i.regs == core::RS1 || bus.fw_cntrl_i.regs == core::RS1_RS2);
        fb  = fwd && (bus.fw_cntrl_i.regs == core::RS2 || bus.fw_cntrl_i.regs == core::RS1_RS2);
        if (bus.fw_cntrl_i.stage == core::MEM_STAGE)
            src = bus.mem_is_load_i ? bus.mem_load_data_i : bus.mem_result_i;
        else
            src = bus.wb_result_i;
        ea  = fa ? src : bus.rs1_data_i;
        eb  = fb ? src : bus.rs2_data_i;
        luh = bus.ex_valid_i && bus.fw_cntrl_i.stage == core::MEM_STAGE &&
              bus.fw_cntrl_i.regs != core::RS_NONE && bus.mem_is_load_i && !bus.mem_load_valid_i;
        if (!rst) begin
            ea = 0; eb = 0; ev = 0; es = 0;
        end else if (m_parked) begin
            ea = m_pa; eb = m_pb; ev = 1; es = 0;
        end else if (m_waiting) begin
            ev = bus.mem_load_valid_i; es = !bus.mem_load_valid_i;
        end else begin
            ev = bus.ex_valid_i && !luh; es = luh;
        end
        if (rst && bus.flush_i) begin
            ev = 0; es = 0;
        end

        chk("op_valid", {63'd0, bus.op_valid_o}, {63'd0, ev});
        chk("stall", {63'd0, bus.stall_o}, {63'd0, es});
        chk("stall_cnt", {48'd0, bus.stall_cnt_o}, 64'(m_cnt));
        if (ev || !rst) begin
            chk("op_a", {32'd0, bus.op_a_o}, {32'd0, ea});
            chk("op_b", {32'd0, bus.op_b_o}, {32'd0, eb});
        end

        if (!rst) begin
            m_parked = 0; m_waiting = 0; m_pa = 0; m_pb = 0; m_cnt = 0;
        end else begin
            if (es && m_cnt < CNT_MAX) m_cnt++;
            if (bus.flush_i) begin
                m_parked = 0; m_waiting = 0;
            end else if (m_parked) begin
                if (bus.ex_ready_i) m_parked = 0;
            end else if (ev && !bus.ex_ready_i) begin
                m_parked = 1; m_waiting = 0; m_pa = ea; m_pb = eb;
            end else if (m_waiting) begin
                if (bus.mem_load_valid_i) m_waiting = 0;
            end else if (luh) begin
                m_waiting = 1;
            end
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        bus.fw_cntrl_i.stage  = core::fw_stage_e'($urandom_range(2, 0));
        bus.fw_cntrl_i.regs   = core::fw_regs_e'($urandom_range(3, 0));
        bus.ex_valid_i        = ($urandom_range(7, 0) != 0);
        bus.flush_i           = ($urandom_range(15, 0) == 0);
        bus.ex_ready_i        = $urandom_range(1, 0) != 0;
        bus.rs1_data_i        = $urandom;
        bus.rs2_data_i        = $urandom;
        bus.mem_result_i      = $urandom;
        bus.mem_is_load_i     = $urandom_range(1, 0) != 0;
        bus.mem_load_valid_i  = ($urandom_range(4, 0) < 2);
        bus.mem_load_data_i   = $urandom;
        bus.wb_result_i       = $urandom;
        rst                   = ($urandom_range(63, 0) != 0);
    endtask

    initial begin
        m_parked = 0; m_waiting = 0; m_pa = 0; m_pb = 0; m_cnt = 0;
        idle();
        rst = 1'b0;
        bus.rs1_data_i = 32'hAAAA_5555;
        next();
        eval();
        chk("rst_op_a", {32'd0, bus.op_a_o}, 64'h0);
        chk("rst_valid", {63'd0, bus.op_valid_o}, 64'h0);
        chk("rst_cnt", {48'd0, bus.stall_cnt_o}, 64'h0);
        next();
        eval(); next();
        rst = 1'b1;

        // No forwarding.
        idle();
        bus.rs1_data_i = 32'h11; bus.rs2_data_i = 32'h22;
        eval();
        chk("nofwd_a", {32'd0, bus.op_a_o}, 64'h11);
        chk("nofwd_b", {32'd0, bus.op_b_o}, 64'h22);
        chk("nofwd_v", {63'd0, bus.op_valid_o}, 64'h1);
        chk("nofwd_s", {63'd0, bus.stall_o}, 64'h0);
        next();

        // MEM forward of an ALU result, then WB forward of rs2 only.
        bus.fw_cntrl_i.stage = core::MEM_STAGE; bus.fw_cntrl_i.regs = core::RS1_RS2;
        bus.mem_result_i = 32'hDEAD;
        eval();
        chk("memfwd_a", {32'd0, bus.op_a_o}, 64'hDEAD);
        chk("memfwd_b", {32'd0, bus.op_b_o}, 64'hDEAD);
        next();
        bus.fw_cntrl_i.stage = core::WB_STAGE; bus.fw_cntrl_i.regs = core::RS2;
        bus.wb_result_i = 32'hBEEF; bus.rs1_data_i = 32'h5;
        eval();
        chk("wbfwd_a", {32'd0, bus.op_a_o}, 64'h5);
        chk("wbfwd_b", {32'd0, bus.op_b_o}, 64'hBEEF);
        next();

        // Load-use: three cycles without data, then data arrives.
        idle();
        bus.fw_cntrl_i.stage = core::MEM_STAGE; bus.fw_cntrl_i.regs = core::RS1;
        bus.mem_is_load_i = 1'b1; bus.mem_load_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("luh_stall", {63'd0, bus.stall_o}, 64'h1);
            chk("luh_valid", {63'd0, bus.op_valid_o}, 64'h0);
            next();
        end
        bus.mem_load_valid_i = 1'b1; bus.mem_load_data_i = 32'hCAFE;
        eval();
        chk("luh_data", {32'd0, bus.op_a_o}, 64'hCAFE);
        chk("luh_dvalid", {63'd0, bus.op_valid_o}, 64'h1);
        chk("luh_cnt", {48'd0, bus.stall_cnt_o}, 64'd3);
        next();

        // Backpressure: operands captured while the producer moves on.
        idle();
        bus.fw_cntrl_i.stage = core::MEM_STAGE; bus.fw_cntrl_i.regs = core::RS1;
        bus.mem_result_i = 32'h1234; bus.ex_ready_i = 1'b0;
        eval();
        chk("bp_a0", {32'd0, bus.op_a_o}, 64'h1234);
        next();
        bus.mem_result_i = 32'h9999;
        for (int i = 0; i < 2; i++) begin
            eval();
            chk("bp_a_hold", {32'd0, bus.op_a_o}, 64'h1234);
            chk("bp_v_hold", {63'd0, bus.op_valid_o}, 64'h1);
            next();
        end
        bus.ex_ready_i = 1'b1;
        eval();
        chk("bp_xfer_a", {32'd0, bus.op_a_o}, 64'h1234);
        next();
        eval();
        chk("bp_after_a", {32'd0, bus.op_a_o}, 64'h9999);
        next();

        // Flush while waiting on load data.
        idle();
        bus.fw_cntrl_i.stage = core::MEM_STAGE; bus.fw_cntrl_i.regs = core::RS1;
        bus.mem_is_load_i = 1'b1;
        eval(); next();
        bus.flush_i = 1'b1;
        eval();
        chk("flush_v", {63'd0, bus.op_valid_o}, 64'h0);
        chk("flush_s", {63'd0, bus.stall_o}, 64'h0);
        next();
        bus.flush_i = 1'b0; bus.mem_is_load_i = 1'b0; bus.mem_result_i = 32'h77;
        eval();
        chk("postflush_a", {32'd0, bus.op_a_o}, 64'h77);
        chk("postflush_v", {63'd0, bus.op_valid_o}, 64'h1);
        next();

        // Reset while holding.
        bus.mem_result_i = 32'h55; bus.ex_ready_i = 1'b0;
        eval(); next();
        rst = 1'b0;
        eval();
        chk("rsthold_a", {32'd0, bus.op_a_o}, 64'h0);
        chk("rsthold_v", {63'd0, bus.op_valid_o}, 64'h0);
        next();
        rst = 1'b1; bus.ex_ready_i = 1'b1; bus.mem_result_i = 32'h66;
        eval();
        chk("rsthold_pass_a", {32'd0, bus.op_a_o}, 64'h66);
        next();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            eval();
            next();
        end

        // Counter saturation under a very long load-use stall.
        idle();
        rst = 1'b1;
        bus.flush_i = 1'b1;
        eval(); next();
        bus.flush_i = 1'b0;
        bus.fw_cntrl_i.stage = core::MEM_STAGE; bus.fw_cntrl_i.regs = core::RS2;
        bus.mem_is_load_i = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            eval(); next();
        end
        eval();
        chk("sat_cnt", {48'd0, bus.stall_cnt_o}, 64'hFFFF);
        next();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
